// File: rtl/fetch_decode_queue.sv
// ---------------------------------------------------------------------------
// fetch_decode_queue
//
// Instruction queue between fetch and decode. Valid {pc, instr} pairs from
// the fetch stage are captured into a small circular FIFO. The oldest pair is
// presented to decode under a valid/ready handshake. The block asserts the
// fetch stall when the queue is full, and a taken-branch flush discards
// everything queued.
//
// Parameters:
//   DEPTH  number of entries (power of two, 2..16)
//   NOP    instruction word driven to decode while the queue is empty
//
// Ports:
//   clk          clock; all state updates on posedge
//   reset        synchronous active-low reset
//   fetch_valid  fetch_pc/fetch_instr form a valid pair this cycle
//   fetch_pc     PC of the fetched instruction
//   fetch_instr  instruction word read at fetch_pc
//   flush        taken branch resolved this cycle; kill queue contents
//   dec_ready    decode accepts the head entry this cycle
//   dec_valid    head entry is valid
//   dec_pc       PC of the head entry (0 when empty)
//   dec_instr    instruction of the head entry (NOP when empty)
//   stallF       queue full; fetch must hold its PC
//   occupancy    number of valid entries
//
// Handshake: a head entry transfers to decode on a rising edge where
// dec_valid && dec_ready && !flush. While dec_valid=1 and dec_ready=0 the
// dec_* outputs hold steady, unless a flush empties the queue. Fetch has no
// ready input. It must watch stallF, and any pair offered while stallF=1 or
// flush=1 is dropped.
// ---------------------------------------------------------------------------
module fetch_decode_queue #(
  parameter int          DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_valid,
  input  logic [31:0]                fetch_pc,
  input  logic [31:0]                fetch_instr,
  input  logic                       flush,
  input  logic                       dec_ready,
  output logic                       dec_valid,
  output logic [31:0]                dec_pc,
  output logic [31:0]                dec_instr,
  output logic                       stallF,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Storage: {pc, instr} per entry. The array is not reset; the pointers and
  // the count alone decide which entries are meaningful.
  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // A full queue refuses a push even when the head pops in the same cycle.
  // This keeps stallF a pure function of the count register.
  assign push = fetch_valid & ~full & ~flush;
  assign pop  = dec_valid & dec_ready & ~flush;

  // Pointer and count state. Reset and flush both empty the queue. Reset
  // comes first so that it also overrides flush.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // DEPTH is a power of two, so the natural pointer overflow gives the
      // modulo-DEPTH wrap.
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry write. Reset is not checked here. A push during reset writes a slot
  // that the cleared count makes invisible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= {fetch_pc, fetch_instr};
    end
  end

  // Head presentation is read combinationally from the array. Outputs are
  // forced to 0/NOP when empty, so decode never sees stale storage.
  logic [63:0] head_entry;
  assign head_entry = mem[head];

  always_comb begin
    dec_valid = ~empty;
    dec_pc    = 32'h0;
    dec_instr = NOP;
    if (!empty) begin
      dec_pc    = head_entry[63:32];
      dec_instr = head_entry[31:0];
    end
  end

  assign stallF    = full;
  assign occupancy = count;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_decode_queue
//
// Directed bench for fetch_decode_queue (DEPTH=4).
//
// Each table record holds the inputs applied for one cycle and the outputs
// expected in that cycle, before the next rising edge. The outputs depend only
// on registered state, so each record's expectation is the state left by the
// records before it. Hand-written sequences cover streaming with pointer wrap
// and a reset asserted mid-operation.
// ---------------------------------------------------------------------------
module tb_fetch_decode_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam int          OW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic          clk;
  logic          reset;
  logic          fetch_valid;
  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_instr;
  logic          flush;
  logic          dec_ready;
  logic          dec_valid;
  logic [31:0]   dec_pc;
  logic [31:0]   dec_instr;
  logic          stallF;
  logic [OW-1:0] occupancy;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  fetch_decode_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .fetch_instr (fetch_instr),
    .flush       (flush),
    .dec_ready   (dec_ready),
    .dec_valid   (dec_valid),
    .dec_pc      (dec_pc),
    .dec_instr   (dec_instr),
    .stallF      (stallF),
    .occupancy   (occupancy)
  );

  // ---------------- checking ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Check every output against an expected state.
  task automatic chk_out(input string tag, input logic ev, input logic [31:0] epc,
                         input logic [31:0] ein, input logic es, input logic [OW-1:0] eo);
    chk({tag, ".dec_valid"}, 32'(dec_valid), 32'(ev));
    chk({tag, ".dec_pc"},    dec_pc,         epc);
    chk({tag, ".dec_instr"}, dec_instr,      ein);
    chk({tag, ".stallF"},    32'(stallF),    32'(es));
    chk({tag, ".occupancy"}, 32'(occupancy), 32'(eo));
  endtask

  task automatic chk_empty(input string tag);
    chk_out(tag, 1'b0, 32'h0, NOP, 1'b0, '0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst, input logic fv, input logic [31:0] pc,
                       input logic [31:0] ins, input logic fl, input logic rdy);
    reset       = rst;
    fetch_valid = fv;
    fetch_pc    = pc;
    fetch_instr = ins;
    flush       = fl;
    dec_ready   = rdy;
  endtask

  // Advance one cycle. Inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        rst;
    logic        fv;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        fl;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ein;
    logic        es;
    logic [OW-1:0] eo;
  } vec_t;

  vec_t vecs[$];

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];

  initial begin
    logic [63:0] e;
    logic [31:0] ins;

    drive(1'b0, 1'b1, 32'h40, 32'h99, 1'b0, 1'b0);

    //            name        rst fv  pc        ins       fl  rdy  ev  epc       ein       es  eo
    // reset held for two edges with fetch_valid=1, then release
    vecs.push_back('{"rst1",   0, 1, 32'h040, 32'h099, 0, 0,   0, 32'h000, NOP,      0, 0});
    vecs.push_back('{"rel0",   1, 0, 32'h000, 32'h000, 0, 0,   0, 32'h000, NOP,      0, 0});
    // fill to full with dec_ready=0
    vecs.push_back('{"fill0",  1, 1, 32'h000, 32'h0A0, 0, 0,   0, 32'h000, NOP,      0, 0});
    vecs.push_back('{"fill1",  1, 1, 32'h004, 32'h0A1, 0, 0,   1, 32'h000, 32'h0A0,  0, 1});
    vecs.push_back('{"fill2",  1, 1, 32'h008, 32'h0A2, 0, 0,   1, 32'h000, 32'h0A0,  0, 2});
    vecs.push_back('{"fill3",  1, 1, 32'h00C, 32'h0A3, 0, 0,   1, 32'h000, 32'h0A0,  0, 3});
    vecs.push_back('{"push5",  1, 1, 32'h010, 32'h0A4, 0, 0,   1, 32'h000, 32'h0A0,  1, 4});
    vecs.push_back('{"full",   1, 0, 32'h000, 32'h000, 0, 0,   1, 32'h000, 32'h0A0,  1, 4});
    // drain in order; 0x10 must not appear
    vecs.push_back('{"drain0", 1, 0, 32'h000, 32'h000, 0, 1,   1, 32'h000, 32'h0A0,  1, 4});
    vecs.push_back('{"drain1", 1, 0, 32'h000, 32'h000, 0, 1,   1, 32'h004, 32'h0A1,  0, 3});
    vecs.push_back('{"drain2", 1, 0, 32'h000, 32'h000, 0, 1,   1, 32'h008, 32'h0A2,  0, 2});
    vecs.push_back('{"drain3", 1, 0, 32'h000, 32'h000, 0, 1,   1, 32'h00C, 32'h0A3,  0, 1});
    vecs.push_back('{"drained",1, 0, 32'h000, 32'h000, 0, 0,   0, 32'h000, NOP,      0, 0});
    // refill, then pop + push while full: push refused
    vecs.push_back('{"rf0",    1, 1, 32'h200, 32'h0B0, 0, 0,   0, 32'h000, NOP,      0, 0});
    vecs.push_back('{"rf1",    1, 1, 32'h204, 32'h0B1, 0, 0,   1, 32'h200, 32'h0B0,  0, 1});
    vecs.push_back('{"rf2",    1, 1, 32'h208, 32'h0B2, 0, 0,   1, 32'h200, 32'h0B0,  0, 2});
    vecs.push_back('{"rf3",    1, 1, 32'h20C, 32'h0B3, 0, 0,   1, 32'h200, 32'h0B0,  0, 3});
    vecs.push_back('{"fullpop",1, 1, 32'h210, 32'h0B4, 0, 1,   1, 32'h200, 32'h0B0,  1, 4});
    vecs.push_back('{"afterfp",1, 0, 32'h000, 32'h000, 0, 0,   1, 32'h204, 32'h0B1,  0, 3});
    // flush at occupancy 3 with a pair offered; then the branch target
    vecs.push_back('{"flush",  1, 1, 32'h020, 32'h0C0, 1, 0,   1, 32'h204, 32'h0B1,  0, 3});
    vecs.push_back('{"target", 1, 1, 32'h100, 32'h0D0, 0, 0,   0, 32'h000, NOP,      0, 0});
    vecs.push_back('{"tgtvis", 1, 0, 32'h000, 32'h000, 0, 0,   1, 32'h100, 32'h0D0,  0, 1});
    vecs.push_back('{"tgtpop", 1, 0, 32'h000, 32'h000, 0, 1,   1, 32'h100, 32'h0D0,  0, 1});
    vecs.push_back('{"tgtdone",1, 0, 32'h000, 32'h000, 0, 0,   0, 32'h000, NOP,      0, 0});

    // The first reset edge leaves state defined; the table starts after it.
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].fv, vecs[i].pc, vecs[i].ins, vecs[i].fl, vecs[i].rdy);
      chk_out(vecs[i].name, vecs[i].ev, vecs[i].epc, vecs[i].ein, vecs[i].es, vecs[i].eo);
      step();
    end

    // ---------- streaming: push and pop every cycle, 20+ cycles ----------
    for (int i = 0; i < 22; i++) begin
      ins = $urandom;
      drive(1'b1, 1'b1, 32'h1000 + 32'(4 * i), ins, 1'b0, 1'b1);
      if (i == 0) begin
        chk_empty("stream_start");
      end else begin
        e = exp_q.pop_front();
        chk_out("stream", 1'b1, e[63:32], e[31:0], 1'b0, OW'(1));
      end
      exp_q.push_back({32'h1000 + 32'(4 * i), ins});
      step();
    end
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    e = exp_q.pop_front();
    chk_out("stream_last", 1'b1, e[63:32], e[31:0], 1'b0, OW'(1));
    step();
    chk_empty("stream_end");
    chk("stream_q_left", 32'(exp_q.size()), 32'd0);

    // ---------- flush on a full queue ----------
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b1, 32'h500 + 32'(4 * i), 32'hF0 + 32'(i), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 1'b1, 32'h600, 32'hF9, 1'b1, 1'b1);
    chk_out("pre_flush_full", 1'b1, 32'h500, 32'hF0, 1'b1, OW'(DEPTH));
    step();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk_empty("post_flush_full");
    step();

    // ---------- reset mid-operation at occupancy 4 ----------
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b1, 32'h300 + 32'(4 * i), 32'hE0 + 32'(i), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 1'b1, 32'h400, 32'hEE, 1'b0, 1'b1);
    chk_out("pre_midrst", 1'b1, 32'h300, 32'hE0, 1'b1, OW'(DEPTH));
    step();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk_empty("midrst");
    for (int i = 0; i < 3; i++) begin
      step();
      chk_empty("midrst_after");
    end
    // queue works normally after release
    drive(1'b1, 1'b1, 32'h700, 32'h77, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk_out("post_rst_push", 1'b1, 32'h700, 32'h77, 1'b0, OW'(1));
    step();

    // ---------- report ----------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
